lc3_trace_capture: RTL and testbench

//  Synthesizable per-instruction trace unit on the lc3 debug ports.

---
 rtl/lc3_trace_capture_if.sv | 11 +
 rtl/lc3_trace_capture.sv | 131 +++++++++++++
 tb/tb_lc3_trace_capture.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_trace_capture_if.sv
// Output word stream of the lc3 trace unit: one 16-bit word per accepted beat,
// with out_last flagging the final word of a record.
interface lc3_trace_capture_if;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/lc3_trace_capture.sv
// Per-instruction trace unit: snapshots the lc3 debug ports on every FETCH entry
// into a record FIFO and streams each record out as ten 16-bit words.
module lc3_trace_capture #(
  parameter logic [5:0] FETCH_STATE = 6'd18,
  parameter int         DEPTH       = 4,
  parameter int         DROP_W      = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [5:0]               currentState,
  input  logic [5:0]               nextState,
  input  logic [15:0]              instruction,
  input  logic [127:0]             regRead,
  lc3_trace_capture_if.master      stream,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [DROP_W-1:0]        overflow_count,
  output logic                     dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int REC_W = 156;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [3:0]       idx;
  logic             prev_fetch;

  logic             fetch;
  logic             trig;
  logic             full;
  logic             accept;
  logic             pop;
  logic             push;
  logic             drop;
  logic [REC_W-1:0] head_rec;
  logic [3:0]       sel_idx;
  logic [15:0]      sel_word;

  assign fetch    = (nextState == FETCH_STATE);
  assign trig     = fetch && !prev_fetch;
  assign full     = (fifo_count == (PTR_W+1)'(DEPTH));
  // Handshake: a word moves when out_valid && out_ready at a rising edge; while
  // out_valid is high and out_ready low, out_data/out_last hold and out_valid stays up.
  assign accept   = stream.out_valid && stream.out_ready;
  assign pop      = accept && (idx == 4'd9);
  assign push     = trig && enable && (!full || pop);
  assign drop     = trig && enable && full && !pop;
  assign head_rec = mem[head];
  assign sel_idx  = (state == IDLE) ? 4'd0 : idx + 4'd1;
  assign dbg_state = (state == SEND);

  always_comb begin
    sel_word = '0;
    case (sel_idx)
      4'd0: sel_word = {2'b00, head_rec[155:150], 2'b00, head_rec[149:144]};
      4'd1: sel_word = head_rec[143:128];
      4'd2: sel_word = head_rec[15:0];
      4'd3: sel_word = head_rec[31:16];
      4'd4: sel_word = head_rec[47:32];
      4'd5: sel_word = head_rec[63:48];
      4'd6: sel_word = head_rec[79:64];
      4'd7: sel_word = head_rec[95:80];
      4'd8: sel_word = head_rec[111:96];
      4'd9: sel_word = head_rec[127:112];
      default: sel_word = '0;
    endcase
  end

  // Storage needs no reset: an entry is only read once fifo_count covers it.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= {currentState, nextState, instruction, regRead};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      idx              <= '0;
      head             <= '0;
      tail             <= '0;
      fifo_count       <= '0;
      overflow_count   <= '0;
      prev_fetch       <= 1'b0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_last  <= 1'b0;
    end else begin
      prev_fetch <= fetch;
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop && (overflow_count != '1)) overflow_count <= overflow_count + 1'b1;

      case (state)
        IDLE: begin
          if (fifo_count != '0) begin
            state            <= SEND;
            idx              <= 4'd0;
            stream.out_valid <= 1'b1;
            stream.out_data  <= sel_word;
            stream.out_last  <= 1'b0;
          end
        end
        SEND: begin
          if (accept) begin
            if (idx == 4'd9) begin
              state            <= IDLE;
              stream.out_valid <= 1'b0;
              stream.out_data  <= '0;
              stream.out_last  <= 1'b0;
            end else begin
              idx             <= idx + 4'd1;
              stream.out_data <= sel_word;
              stream.out_last <= (idx == 4'd8);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_trace_capture.sv
// Self-checking bench for lc3_trace_capture: directed scenarios plus a random
// phase, scored against a record-queue model of the trace stream.
module tb_lc3_trace_capture;

  localparam int DEPTH   = 4;
  localparam int DROP_W  = 8;
  localparam int SAT_MAX = 255;

  // clock / reset
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable;
  logic [5:0]   cur_s;
  logic [5:0]   next_s;
  logic [15:0]  instr;
  logic [127:0] regs;
  logic [2:0]   fifo_count;
  logic [7:0]   overflow_count;
  logic         dbg_state;

  lc3_trace_capture_if bus ();

  lc3_trace_capture #(
    .FETCH_STATE (6'd18),
    .DEPTH       (DEPTH),
    .DROP_W      (DROP_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .currentState   (cur_s),
    .nextState      (next_s),
    .instruction    (instr),
    .regRead        (regs),
    .stream         (bus),
    .fifo_count     (fifo_count),
    .overflow_count (overflow_count),
    .dbg_state      (dbg_state)
  );

  always #5 clk = ~clk;

  // reference model: expected word stream plus record bookkeeping
  logic [15:0] exp_q[$];
  int          rec_cnt;
  int          drops;
  int          pos;
  int          records_seen;
  bit          m_prev;
  int          checks;
  int          failures;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    rec_cnt = 0;
    drops   = 0;
    pos     = 0;
    m_prev  = 1'b0;
  endtask

  // One clock: score the current beat, predict the edge, then check counters after it.
  task automatic tick();
    bit acc;
    bit pop_v;
    bit fetch_v;
    acc = bus.out_valid && bus.out_ready;
    if (bus.out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 32'(bus.out_valid), 32'd0);
      else begin
        chk("word", 32'(bus.out_data), 32'(exp_q[0]));
        chk("last", 32'(bus.out_last), 32'(pos == 9));
      end
    end
    pop_v = acc && (pos == 9);
    if (acc) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      pos = (pos == 9) ? 0 : pos + 1;
    end
    if (pop_v) begin
      rec_cnt--;
      records_seen++;
    end
    fetch_v = (next_s == 6'd18);
    if (fetch_v && !m_prev && enable) begin
      if (rec_cnt < DEPTH) begin
        exp_q.push_back({2'b00, cur_s, 2'b00, next_s});
        exp_q.push_back(instr);
        for (int j = 0; j < 8; j++) exp_q.push_back(regs[16*j +: 16]);
        rec_cnt++;
      end else if (drops < SAT_MAX) drops++;
    end
    m_prev = fetch_v;
    @(posedge clk);
    #1;
    chk("fifo_count", 32'(fifo_count), 32'(rec_cnt));
    chk("overflow_count", 32'(overflow_count), 32'(drops));
    if (rec_cnt == 0) chk("idle_valid", 32'(bus.out_valid), 32'd0);
  endtask

  // driver tasks
  task automatic set_random_record();
    cur_s = 6'($urandom_range(0, 63));
    instr = 16'($urandom);
    regs  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle_state();
    next_s = 6'($urandom_range(0, 17));
  endtask

  task automatic fetch_pulse();
    next_s = 6'd18;
    tick();
    idle_state();
    tick();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    bus.out_ready = 1'b1;
    while ((rec_cnt > 0 || bus.out_valid) && n < budget) begin
      tick();
      n++;
    end
    chk("drained", 32'(rec_cnt != 0 || bus.out_valid), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_overflow", 32'(overflow_count), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    int base;
    int n;
    logic [15:0] r1;
    checks = 0;
    failures = 0;
    records_seen = 0;
    model_clear();
    bus.out_ready = 1'b0;
    enable = 1'b1;
    cur_s  = '0;
    next_s = '0;
    instr  = '0;
    regs   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_data", 32'(bus.out_data), 32'd0);
    chk("reset_last", 32'(bus.out_last), 32'd0);
    chk("reset_fifo_count", 32'(fifo_count), 32'd0);
    chk("reset_overflow", 32'(overflow_count), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // single capture with known register contents, latency and word order
    bus.out_ready = 1'b1;
    for (int j = 0; j < 8; j++) regs[16*j +: 16] = 16'h1000 + 16'(j);
    instr  = 16'h1234;
    cur_s  = 6'd35;
    next_s = 6'd0;
    tick();
    base = records_seen;
    next_s = 6'd18;
    tick();
    chk("lat_edge_n", 32'(bus.out_valid), 32'd0);
    next_s = 6'd0;
    tick();
    chk("lat_edge_n1", 32'(bus.out_valid), 32'd1);
    chk("t2_w0", 32'(bus.out_data), 32'h2312);
    drain(40);
    chk("t2_records", 32'(records_seen - base), 32'd1);

    // FETCH held for five cycles yields one record; re-entry yields another
    base = records_seen;
    set_random_record();
    next_s = 6'd18;
    repeat (5) tick();
    idle_state();
    tick();
    drain(60);
    chk("t3_one", 32'(records_seen - base), 32'd1);
    set_random_record();
    fetch_pulse();
    drain(60);
    chk("t3_two", 32'(records_seen - base), 32'd2);

    // backpressure on word 3 (R1)
    set_random_record();
    r1 = regs[31:16];
    fetch_pulse();
    n = 0;
    while (pos != 3 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_at_r1", 32'(bus.out_data), 32'(r1));
    bus.out_ready = 1'b0;
    repeat (7) begin
      tick();
      chk("t4_hold_data", 32'(bus.out_data), 32'(r1));
      chk("t4_hold_valid", 32'(bus.out_valid), 32'd1);
    end
    drain(60);

    // overflow: six entries into a four-deep FIFO with the sink stalled
    base = records_seen;
    bus.out_ready = 1'b0;
    repeat (6) begin
      set_random_record();
      fetch_pulse();
    end
    chk("t5_count", 32'(fifo_count), 32'd4);
    chk("t5_overflow", 32'(overflow_count), 32'd2);
    drain(200);
    chk("t5_records", 32'(records_seen - base), 32'd4);

    // reset in the middle of a record
    set_random_record();
    fetch_pulse();
    repeat (3) tick();
    chk("t1_sending", 32'(dbg_state), 32'd1);
    do_reset();

    // enable low suppresses capture but the buffered record still drains
    base = records_seen;
    bus.out_ready = 1'b0;
    set_random_record();
    fetch_pulse();
    enable = 1'b0;
    repeat (3) begin
      set_random_record();
      fetch_pulse();
    end
    chk("t6_count", 32'(fifo_count), 32'd1);
    drain(60);
    chk("t6_records", 32'(records_seen - base), 32'd1);
    enable = 1'b1;

    // drop counter saturation
    bus.out_ready = 1'b0;
    repeat (DEPTH + SAT_MAX + 5) fetch_pulse();
    chk("t7_saturated", 32'(overflow_count), 32'(SAT_MAX));
    drain(200);

    // random traffic
    do_reset();
    repeat (800) begin
      if ($urandom_range(0, 3) == 0) next_s = 6'd18;
      else idle_state();
      if ($urandom_range(0, 7) == 0) set_random_record();
      bus.out_ready = ($urandom_range(0, 3) != 0);
      enable = ($urandom_range(0, 7) != 0);
      tick();
    end
    enable = 1'b1;
    idle_state();
    drain(400);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
